rf_wb_queue: RTL and testbench

- Write-port serializer in front of the single-write-port register file of the 2-wide core.
- Accepts up to two writebacks per cycle (lane 0 = older slot, lane 1 = younger) into one in-order circular queue.
- Drains one entry per cycle onto the register file write port (wr_en/addr/data).
- Outputs are registered on posedge so they are stable before the register file's negedge write.

---
 rtl/rf_wb_queue_pkg.sv | 27 ++
 rtl/rf_wbq_fwd_match.sv | 33 +++
 rtl/rf_wb_queue.sv | 146 ++++++++++++++
 tb/tb_rf_wb_queue.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_queue_pkg.sv
// Shared definitions for the register-file writeback queue.
// AWIDTH/DWIDTH normally come from header.vh; the defaults below apply when it is not included.
`ifndef AWIDTH
`define AWIDTH 5
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif

package rf_wb_queue_pkg;

    localparam int WB_AWIDTH = `AWIDTH;
    localparam int WB_DWIDTH = `DWIDTH;
    localparam int WB_LANES  = 2;

    // Queue entry layout for the default widths: {addr, data}.
    typedef struct packed {
        logic [WB_AWIDTH-1:0] addr;
        logic [WB_DWIDTH-1:0] data;
    } wb_entry_t;

    // Pointer width for a power-of-two queue depth.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/rf_wbq_fwd_match.sv
// Single-port newest-match search over an oldest-first list of pending writes.
// Instantiated once per lookup port when RF_WBQ_FWD_EN is defined.
module rf_wbq_fwd_match #(
    parameter int N         = 9,
    parameter int AWIDTH    = 5,
    parameter int DWIDTH    = 32,
    parameter int DROP_ZERO = 1
) (
    input  logic [N-1:0]             cand_valid,
    input  logic [N-1:0][AWIDTH-1:0] cand_addr,
    input  logic [N-1:0][DWIDTH-1:0] cand_data,
    input  logic [AWIDTH-1:0]        lookup_addr,
    output logic                     hit,
    output logic [DWIDTH-1:0]        hit_data
);

    // Index 0 is the oldest candidate, so a later match overrides an earlier one.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < N; i++) begin
            if (cand_valid[i] && (cand_addr[i] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = cand_data[i];
            end
        end
        if ((DROP_ZERO != 0) && (lookup_addr == '0)) begin
            hit      = 1'b0;
            hit_data = '0;
        end
    end

endmodule

// File: rtl/rf_wb_queue.sv
// Two-lane writeback serializer in front of a single-write-port register file.
// Optional feature: define RF_WBQ_FWD_EN to enable the rs/rt forwarding lookup.
module rf_wb_queue
    import rf_wb_queue_pkg::*;
#(
    parameter int AWIDTH    = WB_AWIDTH,
    parameter int DWIDTH    = WB_DWIDTH,
    parameter int DEPTH     = 8,
    parameter int DROP_ZERO = 1
) (
    input  logic                   r_clk,
    input  logic                   r_rst,
    input  logic                   wq_i_valid0,
    input  logic [AWIDTH-1:0]      wq_i_addr0,
    input  logic [DWIDTH-1:0]      wq_i_data0,
    input  logic                   wq_i_valid1,
    input  logic [AWIDTH-1:0]      wq_i_addr1,
    input  logic [DWIDTH-1:0]      wq_i_data1,
    output logic                   wq_o_ready,
    output logic                   wq_o_wr_en,
    output logic [AWIDTH-1:0]      wq_o_addr,
    output logic [DWIDTH-1:0]      wq_o_data,
    output logic [$clog2(DEPTH):0] wq_o_count,
    output logic                   wq_o_empty,
    output logic                   wq_o_full,
    input  logic [AWIDTH-1:0]      wq_i_fwd_addr_rs,
    input  logic [AWIDTH-1:0]      wq_i_fwd_addr_rt,
    output logic                   wq_o_fwd_hit_rs,
    output logic [DWIDTH-1:0]      wq_o_fwd_data_rs,
    output logic                   wq_o_fwd_hit_rt,
    output logic [DWIDTH-1:0]      wq_o_fwd_data_rt
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] slot1;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          acc0;
    logic          acc1;
    logic          pop;
    logic [1:0]    num_acc;

    // Ready looks only at the registered count, leaving room for two pushes.
    assign wq_o_ready = (count <= CW'(DEPTH - 2));
    assign acc0       = wq_i_valid0 && wq_o_ready && !((DROP_ZERO != 0) && (wq_i_addr0 == '0));
    assign acc1       = wq_i_valid1 && wq_o_ready && !((DROP_ZERO != 0) && (wq_i_addr1 == '0));
    assign pop        = (count != '0);
    assign num_acc    = {1'b0, acc0} + {1'b0, acc1};
    assign slot1      = acc0 ? tail + PW'(1) : tail;
    assign count_next = count + CW'(num_acc) - CW'(pop);

    assign wq_o_count = count;
    assign wq_o_empty = (count == '0);
    assign wq_o_full  = (count == CW'(DEPTH));

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            wq_o_wr_en <= 1'b0;
            wq_o_addr  <= '0;
            wq_o_data  <= '0;
        end else begin
            tail  <= tail + PW'(num_acc);
            count <= count_next;
            if (pop) begin
                wq_o_wr_en <= 1'b1;
                wq_o_addr  <= mem[head].addr;
                wq_o_data  <= mem[head].data;
                head       <= head + PW'(1);
            end else begin
                wq_o_wr_en <= 1'b0;
            end
        end
    end

    // NOTE: storage has no reset; occupancy is tracked by count, so stale contents are never read.
    always_ff @(posedge r_clk) begin
        if (acc0) mem[tail]  <= '{addr: wq_i_addr0, data: wq_i_data0};
        if (acc1) mem[slot1] <= '{addr: wq_i_addr1, data: wq_i_data1};
    end

`ifdef RF_WBQ_FWD_EN
    localparam int N = DEPTH + 1;

    logic [N-1:0]             cand_valid;
    logic [N-1:0][AWIDTH-1:0] cand_addr;
    logic [N-1:0][DWIDTH-1:0] cand_data;

    // Candidate 0 is the output stage (oldest), then occupied entries from head onward.
    always_comb begin
        cand_valid    = '0;
        cand_addr     = '0;
        cand_data     = '0;
        cand_valid[0] = wq_o_wr_en;
        cand_addr[0]  = wq_o_addr;
        cand_data[0]  = wq_o_data;
        for (int i = 0; i < DEPTH; i++) begin
            cand_valid[i+1] = (CW'(i) < count);
            cand_addr[i+1]  = mem[head + PW'(i)].addr;
            cand_data[i+1]  = mem[head + PW'(i)].data;
        end
    end

    rf_wbq_fwd_match #(
        .N(N), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .DROP_ZERO(DROP_ZERO)
    ) u_match_rs (
        .cand_valid  (cand_valid),
        .cand_addr   (cand_addr),
        .cand_data   (cand_data),
        .lookup_addr (wq_i_fwd_addr_rs),
        .hit         (wq_o_fwd_hit_rs),
        .hit_data    (wq_o_fwd_data_rs)
    );

    rf_wbq_fwd_match #(
        .N(N), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .DROP_ZERO(DROP_ZERO)
    ) u_match_rt (
        .cand_valid  (cand_valid),
        .cand_addr   (cand_addr),
        .cand_data   (cand_data),
        .lookup_addr (wq_i_fwd_addr_rt),
        .hit         (wq_o_fwd_hit_rt),
        .hit_data    (wq_o_fwd_data_rt)
    );
`else
    logic unused_fwd;
    assign unused_fwd       = ^{wq_i_fwd_addr_rs, wq_i_fwd_addr_rt};
    assign wq_o_fwd_hit_rs  = 1'b0;
    assign wq_o_fwd_data_rs = '0;
    assign wq_o_fwd_hit_rt  = 1'b0;
    assign wq_o_fwd_data_rt = '0;
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// Scoreboard bench for rf_wb_queue: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_rf_wb_queue;
    import rf_wb_queue_pkg::*;

    localparam int AW    = WB_AWIDTH;
    localparam int DW    = WB_DWIDTH;
    localparam int DEPTH = 8;
`ifdef RF_WBQ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                   r_clk = 1'b0;
    logic                   r_rst = 1'b0;
    logic                   wq_i_valid0 = 1'b0, wq_i_valid1 = 1'b0;
    logic [AW-1:0]          wq_i_addr0 = '0, wq_i_addr1 = '0;
    logic [DW-1:0]          wq_i_data0 = '0, wq_i_data1 = '0;
    logic [AW-1:0]          wq_i_fwd_addr_rs = '0, wq_i_fwd_addr_rt = '0;
    logic                   wq_o_ready, wq_o_wr_en, wq_o_empty, wq_o_full;
    logic [AW-1:0]          wq_o_addr;
    logic [DW-1:0]          wq_o_data;
    logic [$clog2(DEPTH):0] wq_o_count;
    logic                   wq_o_fwd_hit_rs, wq_o_fwd_hit_rt;
    logic [DW-1:0]          wq_o_fwd_data_rs, wq_o_fwd_data_rt;

    rf_wb_queue #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH), .DROP_ZERO(1)) dut (
        .r_clk(r_clk), .r_rst(r_rst),
        .wq_i_valid0(wq_i_valid0), .wq_i_addr0(wq_i_addr0), .wq_i_data0(wq_i_data0),
        .wq_i_valid1(wq_i_valid1), .wq_i_addr1(wq_i_addr1), .wq_i_data1(wq_i_data1),
        .wq_o_ready(wq_o_ready), .wq_o_wr_en(wq_o_wr_en), .wq_o_addr(wq_o_addr),
        .wq_o_data(wq_o_data), .wq_o_count(wq_o_count), .wq_o_empty(wq_o_empty),
        .wq_o_full(wq_o_full),
        .wq_i_fwd_addr_rs(wq_i_fwd_addr_rs), .wq_i_fwd_addr_rt(wq_i_fwd_addr_rt),
        .wq_o_fwd_hit_rs(wq_o_fwd_hit_rs), .wq_o_fwd_data_rs(wq_o_fwd_data_rs),
        .wq_o_fwd_hit_rt(wq_o_fwd_hit_rt), .wq_o_fwd_data_rt(wq_o_fwd_data_rt)
    );

    always #5 r_clk = ~r_clk;

    int        vectors     = 0;
    int        miscompares = 0;
    wb_entry_t exp_q[$];
    int        m_count = 0;
    logic      m_wr_en = 1'b0;
    logic [DW-1:0] rf [1 << AW];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // One clock of stimulus; the reference model advances at the same edge.
    task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        output int n_acc);
        logic rdy, ac0, ac1;
        rdy = (m_count <= DEPTH - 2);
        ac0 = v0 && rdy && (a0 != '0);
        ac1 = v1 && rdy && (a1 != '0);
        n_acc = int'(ac0) + int'(ac1);
        wq_i_valid0 = v0; wq_i_addr0 = a0; wq_i_data0 = d0;
        wq_i_valid1 = v1; wq_i_addr1 = a1; wq_i_data1 = d1;
        @(posedge r_clk);
        m_wr_en = (m_count > 0);
        m_count = m_count + n_acc - int'(m_wr_en);
        if (ac0) exp_q.push_back('{addr: a0, data: d0});
        if (ac1) exp_q.push_back('{addr: a1, data: d1});
        #1;
        wq_i_valid0 = 1'b0;
        wq_i_valid1 = 1'b0;
    endtask

    task automatic idle(input int n);
        int dummy;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, dummy);
    endtask

    task automatic drain(input string name);
        int cycles = 0;
        while ((m_count != 0 || m_wr_en) && cycles < 40) begin
            idle(1);
            cycles++;
        end
        idle(1);
        if (cycles >= 40) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: model still busy after %0d cycles", name, cycles);
        end
        check({name, "_leftover"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compares status every cycle and pops the scoreboard on each write.
    initial begin
        wb_entry_t e;
        forever begin
            @(negedge r_clk);
            if (r_rst) begin
                check("wr_en", 64'(wq_o_wr_en), 64'(m_wr_en));
                check("count", 64'(wq_o_count), 64'(m_count));
                check("ready", 64'(wq_o_ready), 64'(m_count <= DEPTH - 2));
                check("empty", 64'(wq_o_empty), 64'(m_count == 0));
                check("full",  64'(wq_o_full),  64'(m_count == DEPTH));
                if (wq_o_wr_en) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                                 wq_o_addr, wq_o_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 64'(wq_o_addr), 64'(e.addr));
                        check("wr_data", 64'(wq_o_data), 64'(e.data));
                    end
                    rf[wq_o_addr] = wq_o_data;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int idx;
        int cycles;
        wb_entry_t seq [20];

        for (int i = 0; i < (1 << AW); i++) rf[i] = '0;

        // Reset state
        #2;
        check("rst_wr_en", 64'(wq_o_wr_en), 64'd0);
        check("rst_addr",  64'(wq_o_addr),  64'd0);
        check("rst_data",  64'(wq_o_data),  64'd0);
        check("rst_count", 64'(wq_o_count), 64'd0);
        check("rst_empty", 64'(wq_o_empty), 64'd1);
        check("rst_full",  64'(wq_o_full),  64'd0);
        check("rst_ready", 64'(wq_o_ready), 64'd1);
        #10 r_rst = 1'b1;
        @(posedge r_clk); #1;

        // Single lane-0 write
        step(1'b1, AW'(5), DW'('hAA), 1'b0, '0, '0, n);
        idle(1);
        check("single_wr_en", 64'(wq_o_wr_en), 64'd1);
        check("single_addr",  64'(wq_o_addr),  64'd5);
        check("single_data",  64'(wq_o_data),  64'hAA);
        drain("single");

        // Same-address dual write resolves youngest-last
        step(1'b1, AW'(7), DW'(1), 1'b1, AW'(7), DW'(2), n);
        drain("dual");
        check("rf7_final", 64'(rf[7]), 64'd2);

        // Sustained dual-lane input: fill, wrap, back-pressure
        for (int i = 0; i < 20; i++) seq[i] = '{addr: AW'(i + 1), data: DW'(32'h100 + i)};
        idx = 0;
        cycles = 0;
        while (idx < 20 && cycles < 200) begin
            if (idx + 1 < 20)
                step(1'b1, seq[idx].addr, seq[idx].data, 1'b1, seq[idx+1].addr, seq[idx+1].data, n);
            else
                step(1'b1, seq[idx].addr, seq[idx].data, 1'b0, '0, '0, n);
            idx += n;
            cycles++;
        end
        drain("stream");

        // Address-0 drop on lane 0
        step(1'b1, AW'(0), DW'('h55), 1'b1, AW'(3), DW'('h33), n);
        drain("drop0");
        check("rf3", 64'(rf[3]), 64'h33);
        check("rf0", 64'(rf[0]), 64'd0);

        // Async reset mid-drain
        step(1'b1, AW'(11), DW'('hB1), 1'b1, AW'(12), DW'('hB2), n);
        step(1'b1, AW'(13), DW'('hB3), 1'b1, AW'(14), DW'('hB4), n);
        #2 r_rst = 1'b0;
        #1;
        check("mid_rst_wr_en", 64'(wq_o_wr_en), 64'd0);
        check("mid_rst_addr",  64'(wq_o_addr),  64'd0);
        check("mid_rst_data",  64'(wq_o_data),  64'd0);
        check("mid_rst_count", 64'(wq_o_count), 64'd0);
        check("mid_rst_empty", 64'(wq_o_empty), 64'd1);
        m_count = 0;
        m_wr_en = 1'b0;
        exp_q.delete();
        #3 r_rst = 1'b1;
        idle(5);

        // Forwarding: newest of two pending writes to r9
        step(1'b1, AW'(9), DW'('h10), 1'b1, AW'(9), DW'('h20), n);
        wq_i_fwd_addr_rs = AW'(9);
        wq_i_fwd_addr_rt = AW'(4);
        #1;
        check("fwd_rs_hit_q",  64'(wq_o_fwd_hit_rs),  64'(FWD));
        check("fwd_rs_data_q", 64'(wq_o_fwd_data_rs), FWD ? 64'h20 : 64'd0);
        check("fwd_rt_hit",    64'(wq_o_fwd_hit_rt),  64'd0);
        idle(1);
        check("fwd_rs_hit_mix",  64'(wq_o_fwd_hit_rs),  64'(FWD));
        check("fwd_rs_data_mix", 64'(wq_o_fwd_data_rs), FWD ? 64'h20 : 64'd0);
        idle(1);
        check("fwd_rs_hit_out",  64'(wq_o_fwd_hit_rs),  64'(FWD));
        check("fwd_rs_data_out", 64'(wq_o_fwd_data_rs), FWD ? 64'h20 : 64'd0);
        wq_i_fwd_addr_rt = AW'(0);
        #1;
        check("fwd_rt_zero", 64'(wq_o_fwd_hit_rt), 64'd0);
        idle(1);
        check("fwd_rs_hit_done", 64'(wq_o_fwd_hit_rs), 64'd0);
        drain("fwd");
        check("rf9", 64'(rf[9]), 64'h20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
